// File: rtl/cache_pkg.sv
// Shared cache-hierarchy constants and the L1/L2 arbiter state encoding.
package cache_pkg;

    localparam int unsigned CACHE_TAG_W   = 18;
    localparam int unsigned CACHE_INDEX_W = 8;
    localparam int unsigned CACHE_LINE_W  = 512;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUSY = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational request picker: rotating priority from i_ptr (MODE 0) or
// lowest index wins (MODE 1). The pointer register lives in the caller.
module rr_arbiter
    import cache_pkg::*;
#(
    parameter int unsigned N    = 2,
    parameter int unsigned MODE = 0
) (
    input  logic [N-1:0]         i_req,
    input  logic [$clog2(N)-1:0] i_ptr,
    output logic [N-1:0]         o_gnt_c,
    output logic [$clog2(N)-1:0] o_gnt_id_c
);

    localparam int unsigned ID_W = $clog2(N);

    logic [ID_W-1:0] w_idx;
    logic            w_found;

    // Walk the requesters in priority order; the first one set wins.
    always_comb begin
        o_gnt_c    = '0;
        o_gnt_id_c = '0;
        w_found    = 1'b0;
        w_idx      = '0;
        for (int unsigned k = 0; k < N; k++) begin
            w_idx = (MODE == 0) ? ID_W'((32'(i_ptr) + k) % N) : ID_W'(k);
            if (!w_found && i_req[w_idx]) begin
                w_found        = 1'b1;
                o_gnt_c[w_idx] = 1'b1;
                o_gnt_id_c     = w_idx;
            end
        end
    end

endmodule

// File: rtl/l1_l2_arbiter.sv
// N-requester arbiter between private L1 caches and the shared L2: one
// outstanding L2 transaction, latched request fields, sticky hung-L2 watchdog.
module l1_l2_arbiter
    import cache_pkg::*;
#(
    parameter int unsigned NUM_REQ  = 2,
    parameter int unsigned TAG_W    = CACHE_TAG_W,
    parameter int unsigned INDEX_W  = CACHE_INDEX_W,
    parameter int unsigned LINE_W   = CACHE_LINE_W,
    parameter int unsigned ARB_MODE = 0,
    parameter int unsigned TIMEOUT  = 1024
) (
    input  logic                         clk,
    input  logic                         nrst,
    input  logic [NUM_REQ-1:0]           read_L1_L2,
    input  logic [NUM_REQ-1:0]           write_L1_L2,
    input  logic [NUM_REQ*TAG_W-1:0]     tag_L1_L2,
    input  logic [NUM_REQ*INDEX_W-1:0]   index_L1_L2,
    input  logic [NUM_REQ*TAG_W-1:0]     write_tag_L1_L2,
    input  logic [NUM_REQ*INDEX_W-1:0]   write_index_L1_L2,
    input  logic [NUM_REQ*LINE_W-1:0]    write_data_L1_L2,
    output logic [NUM_REQ-1:0]           ready_L2_L1,
    output logic [LINE_W-1:0]            read_data_L2_L1,
    output logic                         read_ARB_L2,
    output logic                         write_ARB_L2,
    output logic [TAG_W-1:0]             tag_ARB_L2,
    output logic [INDEX_W-1:0]           index_ARB_L2,
    output logic [TAG_W-1:0]             write_tag_ARB_L2,
    output logic [INDEX_W-1:0]           write_index_ARB_L2,
    output logic [LINE_W-1:0]            write_data_ARB_L2,
    input  logic                         ready_L2_ARB,
    input  logic [LINE_W-1:0]            read_data_L2_ARB,
    output logic [$clog2(NUM_REQ)-1:0]   grant_id,
    output logic                         timeout_err
);

    localparam int unsigned ID_W  = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    arb_state_e          r_state;
    arb_state_e          w_state_next;
    logic [ID_W-1:0]     r_ptr;
    logic [CNT_W-1:0]    r_cnt;
    logic [NUM_REQ-1:0]  w_req;
    logic [NUM_REQ-1:0]  w_gnt;
    logic [ID_W-1:0]     w_gnt_id;
    logic                w_grant;
    logic                w_done;
    logic                w_to_hit;

    assign w_req    = read_L1_L2 | write_L1_L2;
    assign w_to_hit = (TIMEOUT != 0) && (r_cnt == CNT_W'(TIMEOUT - 1));

    rr_arbiter #(
        .N    (NUM_REQ),
        .MODE (ARB_MODE)
    ) u_pick (
        .i_req      (w_req),
        .i_ptr      (r_ptr),
        .o_gnt_c    (w_gnt),
        .o_gnt_id_c (w_gnt_id)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) r_state <= ARB_IDLE;
        else       r_state <= w_state_next;
    end

    // Next state plus one-cycle grant / completion strobes for the datapath.
    always_comb begin
        w_state_next = r_state;
        w_grant      = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            ARB_IDLE: begin
                if (|w_req) begin
                    w_grant      = 1'b1;
                    w_state_next = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                if (ready_L2_ARB) begin
                    w_done       = 1'b1;
                    w_state_next = ARB_RESP;
                end
            end
            ARB_RESP: w_state_next = ARB_IDLE;
            default:  w_state_next = ARB_IDLE;
        endcase
    end

    // Request latches, response routing, rr pointer and watchdog.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            ready_L2_L1        <= '0;
            read_data_L2_L1    <= '0;
            read_ARB_L2        <= 1'b0;
            write_ARB_L2       <= 1'b0;
            tag_ARB_L2         <= '0;
            index_ARB_L2       <= '0;
            write_tag_ARB_L2   <= '0;
            write_index_ARB_L2 <= '0;
            write_data_ARB_L2  <= '0;
            grant_id           <= '0;
            timeout_err        <= 1'b0;
            r_ptr              <= '0;
            r_cnt              <= '0;
        end else begin
            ready_L2_L1 <= '0;
            if (w_grant) begin
                read_ARB_L2        <= |(read_L1_L2 & w_gnt);
                write_ARB_L2       <= |(write_L1_L2 & w_gnt);
                tag_ARB_L2         <= tag_L1_L2[32'(w_gnt_id) * TAG_W +: TAG_W];
                index_ARB_L2       <= index_L1_L2[32'(w_gnt_id) * INDEX_W +: INDEX_W];
                write_tag_ARB_L2   <= write_tag_L1_L2[32'(w_gnt_id) * TAG_W +: TAG_W];
                write_index_ARB_L2 <= write_index_L1_L2[32'(w_gnt_id) * INDEX_W +: INDEX_W];
                write_data_ARB_L2  <= write_data_L1_L2[32'(w_gnt_id) * LINE_W +: LINE_W];
                grant_id           <= w_gnt_id;
                r_ptr              <= (w_gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : w_gnt_id + ID_W'(1);
                r_cnt              <= '0;
            end
            if (w_done) begin
                read_data_L2_L1       <= read_data_L2_ARB;
                read_ARB_L2           <= 1'b0;
                write_ARB_L2          <= 1'b0;
                tag_ARB_L2            <= '0;
                index_ARB_L2          <= '0;
                write_tag_ARB_L2      <= '0;
                write_index_ARB_L2    <= '0;
                write_data_ARB_L2     <= '0;
                ready_L2_L1[grant_id] <= 1'b1;
            end else if (r_state == ARB_BUSY) begin
                // Count saturates at TIMEOUT; the error flag stays until reset.
                if (r_cnt != CNT_W'(TIMEOUT)) r_cnt <= r_cnt + CNT_W'(1);
                if (w_to_hit) timeout_err <= 1'b1;
            end
        end
    end

endmodule
